// File: rtl/golden_nonce_uart_tx_if.sv
// Nonce event input and UART/status outputs of the golden-nonce reporter.
// The master modport drives nonce events; the slave modport is the transmitter.
`timescale 1ns/1ps
interface golden_nonce_uart_tx_if #(
    parameter int FIFO_DEPTH_LOG2 = 2
);
    logic                     nonce_valid;
    logic [31:0]              nonce;
    logic                     uart_tx;
    logic                     busy;
    logic                     overflow;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    modport master (
        output nonce_valid, nonce,
        input  uart_tx, busy, overflow, fifo_count
    );

    modport slave (
        input  nonce_valid, nonce,
        output uart_tx, busy, overflow, fifo_count
    );
endinterface

// File: rtl/golden_nonce_uart_tx.sv
// Buffers golden nonces in a small FIFO and sends each as 8N1 bytes, MSB byte first.
// Latency: nonce sampled at E0 into an empty idle block drives uart_tx low after E2.
// Backpressure: none upstream; a nonce arriving at a full FIFO with no pop is dropped and overflow sticks.
// Optional checksum byte (XOR of the nonce bytes) when NONCE_TX_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module golden_nonce_uart_tx #(
    parameter int BAUD_DIV        = 868,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                  hash_clk,
    input  logic                  reset,
    golden_nonce_uart_tx_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
`ifdef NONCE_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   word_q, word_d;
    logic [7:0]    sh_q, sh_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic [31:0]   mem_q [DEPTH];

    logic fifo_full, pop, push, baud_wrap;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = w[31:24];
            3'd1:    b = w[23:16];
            3'd2:    b = w[15:8];
            3'd3:    b = w[7:0];
`ifdef NONCE_TX_CHECKSUM_EN
            default: b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`else
            default: b = 8'h00;
`endif
        endcase
        return b;
    endfunction

    assign fifo_full = (count_q == FULL_CNT);
    assign pop       = (state_q == IDLE) && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = bus.nonce_valid && (!fifo_full || pop);
    assign baud_wrap = (baud_q == BAUD_MAX);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        ovf_d  = ovf_q | (bus.nonce_valid & fifo_full & ~pop);
        busy_d = (state_q != IDLE) || (count_q != '0);
    end

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        sh_d       = sh_q;
        baud_d     = (state_q == IDLE || baud_wrap) ? '0 : baud_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (pop) begin
                    word_d     = mem_q[rd_ptr_q];
                    sh_d       = mem_q[rd_ptr_q][31:24];
                    byte_idx_d = 3'd0;
                    bit_d      = 3'd0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    sh_d = sh_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        sh_d       = pick_byte(word_q, byte_idx_q + 3'd1);
                        state_d    = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Line follows the state one cycle later so uart_tx comes straight off a flop.
        tx_d = (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : 1'b1;
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            sh_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            sh_q       <= sh_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.nonce;
        end
    end

    assign bus.uart_tx    = tx_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_count = count_q;
endmodule
